reg_file_tmp: RTL and testbench
===============================

Name: reg_file_tmp

Overview:
- Temporary (speculative) register-status file: 32 entries of 42 bits, one entry per architectural destination register.
- Used by the issue/commit logic to track each in-flight destination: rd_reg, PC, instruction type, speculative data/valid flags and valid bit.
- One synchronous write port with two modes (new entry, status update) and two independent combinational read ports.

Parameters:
- DEPTH, 32, number of entries.
- AW, 5, address width (log2 DEPTH).
- DW, 42, entry width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- Data_In  in  42  write data; field map below.
- Waddr  in  5  write address.
- New_entry  in  1  write full entry at Waddr.
- Update_entry  in  1  update status bits of entry at Waddr.
- Rd_Addr1  in  5  read address, port 1.
- Data_out1  out  42  entry at Rd_Addr1.
- Rd_Addr2  in  5  read address, port 2.
- Data_out2  out  42  entry at Rd_Addr2.

Behaviour:
- Entry field map:
  - [41:37] rd_reg
  - [36:5] PC
  - [4:3] Inst_type
  - [2] spec_data
  - [1] spec_valid
  - [0] valid
- Reset: on a rising edge with reset==0, all 32 entries are cleared to 42'h0. Reset overrides both write enables. Outputs therefore read 0 for any address after reset.
- New_entry==1 (reset==1): mem[Waddr] <= Data_In (all 42 bits) at the rising edge.
- Update_entry==1, New_entry==0: only mem[Waddr][2:0] <= Data_In[2:0]. Bits [41:3] are retained; Data_In[41:3] are ignored.
- Both enables high: New_entry has priority and a full write occurs.
- Neither enable high: no state change.
- Reads are asynchronous: Data_outN = mem[Rd_AddrN], combinational, zero latency. Both ports may address the same or different entries freely.
- Read during write to the same address: the read returns the pre-edge (old) value until the edge, then the new value. No bypass unless the optional feature is enabled.
- Addresses are exactly 5 bits; every value 0..31 is valid, with no out-of-range case. Upstream truncation (e.g. index 32) wraps to entry 0.
- Writes affect only the addressed entry; all others hold.

Optional Feature:
- Macro: REGFILETMP_BYPASS_EN.
- Defined: each read port forwards write data combinationally when the write enable is active and Rd_AddrN==Waddr.
  - New_entry: the whole Data_In is forwarded.
  - Update_entry only: {mem[Waddr][41:3], Data_In[2:0]} is forwarded.
  - Forwarding is suppressed while reset==0.
- Not defined: pure array read, old value until the clock edge.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read all addresses on both ports -> Data_out1 = Data_out2 = 0 everywhere.
- Fill: for i=0..31 apply New_entry=1, Waddr=i, Data_In={i[4:0], 32'h80000001, 2'b10, 1'b1, 1'b0, 1'b1}. Then sweep Rd_Addr1=i, Rd_Addr2=i+1 (mod 32) -> each port returns the matching pattern. Example: addr 5 reads {5'd5, 32'h80000001, 5'b10101}.
- Wrap: New_entry with Waddr=0 (index 32 truncated) and new data -> only entry 0 changes; entry 31 and the others are unchanged.
- Update: after Fill, apply Update_entry=1, New_entry=0, Waddr=3, Data_In={5'd0, 32'h0, 2'b11, 3'b111}. Then Rd_Addr1=3 -> {5'd3, 32'h80000001, 2'b10, 3'b111}; entries 2 and 4 are unchanged.
- Priority/read timing: New_entry=Update_entry=1 to Waddr=7 with data X -> entry 7 == X after the edge. Before the edge, Rd_Addr1=7 shows the old value; with REGFILETMP_BYPASS_EN it shows X.
- Reset mid-operation: assert reset=0 with New_entry=1 in the same cycle -> no write takes effect and all entries read 0.

Source files
------------

// File: rtl/reg_file_tmp.sv
// Speculative register-status file: 32 x 42-bit entries, one write port (full write or
// status-only update) and two asynchronous read ports. Define REGFILETMP_BYPASS_EN for write-to-read forwarding.
module reg_file_tmp #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 42
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] Data_In,
    input  logic [AW-1:0] Waddr,
    input  logic          New_entry,
    input  logic          Update_entry,
    input  logic [AW-1:0] Rd_Addr1,
    output logic [DW-1:0] Data_out1,
    input  logic [AW-1:0] Rd_Addr2,
    output logic [DW-1:0] Data_out2
);

    // Status field {spec_data, spec_valid, valid} is the only part an update touches.
    localparam int STAT_W = 3;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (New_entry) begin
            mem[Waddr] <= Data_In;
        end else if (Update_entry) begin
            mem[Waddr][STAT_W-1:0] <= Data_In[STAT_W-1:0];
        end
    end

`ifdef REGFILETMP_BYPASS_EN
    // Value the addressed entry will hold after this edge, or the stored value if untouched.
    function automatic logic [DW-1:0] fwd_read(input logic [AW-1:0] raddr,
                                               input logic [DW-1:0] stored);
        logic [DW-1:0] res;
        res = stored;
        if (reset && (raddr == Waddr)) begin
            if (New_entry) begin
                res = Data_In;
            end else if (Update_entry) begin
                res = {stored[DW-1:STAT_W], Data_In[STAT_W-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        Data_out1 = fwd_read(Rd_Addr1, mem[Rd_Addr1]);
        Data_out2 = fwd_read(Rd_Addr2, mem[Rd_Addr2]);
    end
`else
    always_comb begin
        Data_out1 = mem[Rd_Addr1];
        Data_out2 = mem[Rd_Addr2];
    end
`endif

endmodule

// File: tb/tb_reg_file_tmp.sv
// Directed bench for reg_file_tmp: reference array model feeds an expected-value queue
// that is drained and compared whenever the read ports are sampled.
module tb_reg_file_tmp;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [41:0] Data_In = '0;
    logic [4:0]  Waddr = '0;
    logic        New_entry = 1'b0;
    logic        Update_entry = 1'b0;
    logic [4:0]  Rd_Addr1 = '0;
    logic [41:0] Data_out1;
    logic [4:0]  Rd_Addr2 = '0;
    logic [41:0] Data_out2;

    logic [41:0] model [32];
    logic [41:0] exp_q [$];
    int compared = 0;
    int mismatched = 0;

    reg_file_tmp dut (
        .clock(clock), .reset(reset), .Data_In(Data_In), .Waddr(Waddr),
        .New_entry(New_entry), .Update_entry(Update_entry),
        .Rd_Addr1(Rd_Addr1), .Data_out1(Data_out1),
        .Rd_Addr2(Rd_Addr2), .Data_out2(Data_out2)
    );

    always #5 clock = ~clock;

    function automatic logic [41:0] fill_pat(input int i);
        logic [4:0] a;
        a = i[4:0];
        return {a, 32'h80000001, 2'b10, 1'b1, 1'b0, 1'b1};
    endfunction

    // Drive both read addresses, queue expectations, then sample and compare.
    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [41:0] e1, input logic [41:0] e2);
        logic [41:0] exp1, exp2;
        Rd_Addr1 = a1;
        Rd_Addr2 = a2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        #1;
        exp1 = exp_q.pop_front();
        exp2 = exp_q.pop_front();
        compared++;
        assert (Data_out1 === exp1) else begin
            mismatched++;
            $error("FAIL %s port1 addr=%0d observed=%h expected=%h", tag, a1, Data_out1, exp1);
        end
        compared++;
        assert (Data_out2 === exp2) else begin
            mismatched++;
            $error("FAIL %s port2 addr=%0d observed=%h expected=%h", tag, a2, Data_out2, exp2);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            read_check(tag, 5'(i), 5'((i + 1) % 32), model[i], model[(i + 1) % 32]);
        end
    endtask

    // One write cycle; the model follows the documented write rules.
    task automatic do_write(input logic ne, input logic ue, input logic [4:0] wa,
                            input logic [41:0] d);
        @(posedge clock);
        #1;
        New_entry = ne;
        Update_entry = ue;
        Waddr = wa;
        Data_In = d;
        @(posedge clock);
        #1;
        if (ne) model[wa] = d;
        else if (ue) model[wa][2:0] = d[2:0];
        New_entry = 1'b0;
        Update_entry = 1'b0;
    endtask

    initial begin
        logic [5:0]  idx32;
        logic [41:0] x_val, old7, upd_exp, mid_exp;

        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset for two cycles, also with the memory never written before.
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        sweep("reset");

        // Fill every entry.
        for (int i = 0; i < 32; i++) do_write(1'b1, 1'b0, 5'(i), fill_pat(i));
        sweep("fill");
        read_check("fill_addr5", 5'd5, 5'd5, {5'd5, 32'h80000001, 5'b10101},
                   {5'd5, 32'h80000001, 5'b10101});

        // Index 32 truncates to entry 0.
        idx32 = 6'd32;
        do_write(1'b1, 1'b0, idx32[4:0], 42'h2AB_CDEF_0123);
        read_check("wrap", 5'd0, 5'd31, 42'h2AB_CDEF_0123, fill_pat(31));
        sweep("wrap_all");

        // Status-only update ignores the upper Data_In bits.
        do_write(1'b0, 1'b1, 5'd3, {5'd0, 32'h0, 2'b11, 3'b111});
        read_check("update", 5'd3, 5'd2, {5'd3, 32'h80000001, 2'b10, 3'b111}, fill_pat(2));
        read_check("update_nb", 5'd4, 5'd3, fill_pat(4), {5'd3, 32'h80000001, 2'b10, 3'b111});

        // Update read-during-write on entry 10.
        @(posedge clock);
        #1;
        Update_entry = 1'b1;
        Waddr = 5'd10;
        Data_In = 42'h3FF_FFFF_FFFA;
`ifdef REGFILETMP_BYPASS_EN
        upd_exp = {model[10][41:3], 3'b010};
`else
        upd_exp = model[10];
`endif
        read_check("upd_pre_edge", 5'd10, 5'd11, upd_exp, model[11]);
        @(posedge clock);
        #1;
        Update_entry = 1'b0;
        model[10][2:0] = 3'b010;
        read_check("upd_post_edge", 5'd10, 5'd11, model[10], model[11]);

        // Both enables: full write wins; check read timing around the edge.
        x_val = 42'h155_5555_5555;
        old7 = model[7];
        @(posedge clock);
        #1;
        New_entry = 1'b1;
        Update_entry = 1'b1;
        Waddr = 5'd7;
        Data_In = x_val;
`ifdef REGFILETMP_BYPASS_EN
        read_check("prio_pre_edge", 5'd7, 5'd6, x_val, model[6]);
`else
        read_check("prio_pre_edge", 5'd7, 5'd6, old7, model[6]);
`endif
        @(posedge clock);
        #1;
        New_entry = 1'b0;
        Update_entry = 1'b0;
        model[7] = x_val;
        read_check("prio_post_edge", 5'd7, 5'd8, x_val, model[8]);
        sweep("prio_all");

        // Reset with a concurrent write: no forwarding, no write, everything clears.
        @(posedge clock);
        #1;
        reset = 1'b0;
        New_entry = 1'b1;
        Waddr = 5'd9;
        Data_In = 42'h0AA_AAAA_AAAA;
        mid_exp = model[9];
        read_check("rst_pre_edge", 5'd9, 5'd0, mid_exp, model[0]);
        @(posedge clock);
        #1;
        reset = 1'b1;
        New_entry = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        sweep("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
